axi_lite_fifo_slave: RTL and testbench

AXI_LITE_FIFO_SLAVE -- requirements
Module: axi_lite_fifo_slave

---
 rtl/axi_lite_fifo_slave.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_lite_fifo_slave.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_fifo_slave.sv
// AXI4-Lite slave exposing a word FIFO plus STATUS, CTRL (flush) and THRESH
// registers. The write and read channels each run a small two-state FSM, and
// IRQ is a registered "count >= threshold" flag.
module axi_lite_fifo_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  input  logic [2:0]            AWPROT,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  input  logic [2:0]            ARPROT,
  output logic                  ARREADY,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  IRQ
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_THRESH = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_thresh;
  logic              r_irq;

  // Channel state
  w_state_t          r_wstate;
  r_state_t          r_rstate;
  logic              r_live;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_arready;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;

  // Decode / datapath wires
  logic [1:0]        w_aw_sel;
  logic [1:0]        w_ar_sel;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_flush;
  logic [1:0]        w_wr_resp;
  logic [1:0]        w_rd_resp;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_thresh_merged;
  logic              w_unused;

  assign w_aw_sel = AWADDR[3:2];
  assign w_ar_sel = ARADDR[3:2];

  // Address and data are taken together, only when both are offered. r_live
  // keeps the ready low through reset even if a master holds the valids high.
  assign w_wr_acc = r_live && (r_wstate == W_IDLE) && AWVALID && WVALID;
  assign w_rd_acc = r_arready && ARVALID;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Full/empty come from pre-cycle state, so a same-cycle push and pop are
  // judged independently of each other.
  assign w_push_ok = w_wr_acc && (w_aw_sel == A_DATA) && !w_full && (&WSTRB);
  assign w_pop_ok  = w_rd_acc && (w_ar_sel == A_DATA) && !w_empty;
  assign w_flush   = w_wr_acc && (w_aw_sel == A_CTRL) && WSTRB[0] && WDATA[0];

  assign AWREADY = w_wr_acc;
  assign WREADY  = w_wr_acc;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RRESP   = r_rresp;
  assign RDATA   = r_rdata;
  assign IRQ     = r_irq;

  // PROT, low address bits and the upper THRESH lanes carry no meaning here.
  assign w_unused = ^{AWPROT, ARPROT, AWADDR, ARADDR, w_thresh_merged};

  // STATUS snapshot: full, empty and current count
  always_comb begin
    w_status = '0;
    w_status[DATA_W-1] = w_full;
    w_status[DATA_W-2] = w_empty;
    w_status[CNT_W-1:0] = r_count;
  end

  // Merge THRESH with the incoming write, lane by lane under WSTRB
  always_comb begin
    w_thresh_merged = DATA_W'(r_thresh);
    for (int b = 0; b < STRB_W; b++) begin
      if (WSTRB[b]) w_thresh_merged[8*b +: 8] = WDATA[8*b +: 8];
    end
  end

  // Write response: DATA pushes can be refused, STATUS is read-only
  always_comb begin
    w_wr_resp = RESP_OKAY;
    case (w_aw_sel)
      A_DATA:   w_wr_resp = w_push_ok ? RESP_OKAY : RESP_SLVERR;
      A_STATUS: w_wr_resp = RESP_SLVERR;
      default:  w_wr_resp = RESP_OKAY;
    endcase
  end

  // Read data/response selection for the address being accepted
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (w_ar_sel)
      A_DATA: begin
        if (w_empty) w_rd_resp = RESP_SLVERR;
        else         w_rd_data = r_mem[r_rptr];
      end
      A_STATUS: w_rd_data = w_status;
      A_CTRL:   w_rd_resp = RESP_SLVERR;
      default:  w_rd_data = DATA_W'(r_thresh);
    endcase
  end

  // FIFO storage is never reset; an empty count hides stale words
  always_ff @(posedge ACLK) begin
    if (w_push_ok) r_mem[r_wptr] <= WDATA;
  end

  // Pointers and count; a flush wins over any same-cycle push or pop
  always_ff @(posedge ACLK) begin
    if (ARESET || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  // THRESH register, byte-lane writable
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_thresh <= CNT_W'(DEPTH / 2);
    end else if (w_wr_acc && (w_aw_sel == A_THRESH)) begin
      r_thresh <= w_thresh_merged[CNT_W-1:0];
    end
  end

  // IRQ follows count/THRESH one cycle late; THRESH of 0 always fires
  always_ff @(posedge ACLK) begin
    if (ARESET) r_irq <= 1'b0;
    else        r_irq <= (r_thresh == '0) || (r_count >= r_thresh);
  end

  // Marks the first cycle after reset release
  always_ff @(posedge ACLK) begin
    if (ARESET) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Write channel FSM: accept AW+W together, then hold B until taken
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate <= W_IDLE;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_acc) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_resp;
            r_wstate <= W_RESP;
          end
        end
        default: begin
          if (BREADY) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read channel FSM: register data on AR acceptance, hold R until taken
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_rd_acc) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        default: begin
          if (RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_fifo_slave.sv
// Bench for axi_lite_fifo_slave: directed scenarios plus a randomized run
// checked against a queue-based model of the register map.
module tb_axi_lite_fifo_slave;

  localparam int DEPTH = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic [2:0]  AWPROT;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic [2:0]  ARPROT;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        IRQ;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_q[$];
  int          model_thresh = DEPTH / 2;

  always #5 ACLK = ~ACLK;

  axi_lite_fifo_slave #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .IRQ(IRQ)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_status();
    logic [31:0] v;
    v = 32'(model_q.size());
    if (model_q.size() == DEPTH) v = v | 32'h8000_0000;
    if (model_q.size() == 0)     v = v | 32'h4000_0000;
    return v;
  endfunction

  function automatic logic exp_irq();
    return (model_thresh == 0) || (model_q.size() >= model_thresh);
  endfunction

  task automatic exp_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    case (a[3:2])
      2'd0: begin
        if (model_q.size() < DEPTH && s == 4'hF) begin
          model_q.push_back(d);
          resp = 2'b00;
        end else begin
          resp = 2'b10;
        end
      end
      2'd1: resp = 2'b10;
      2'd2: begin
        if (s[0] && d[0]) model_q.delete();
        resp = 2'b00;
      end
      default: begin
        if (s[0]) model_thresh = int'(d & 32'h1F);
        resp = 2'b00;
      end
    endcase
  endtask

  task automatic exp_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    d = 32'h0;
    resp = 2'b00;
    case (a[3:2])
      2'd0: begin
        if (model_q.size() > 0) d = model_q.pop_front();
        else resp = 2'b10;
      end
      2'd1: d = exp_status();
      2'd2: resp = 2'b10;
      default: d = 32'(model_thresh);
    endcase
  endtask

  // ---------------- bus drivers ----------------
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    #1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (AWREADY !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
    end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (BVALID !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (BVALID !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL b_timeout: BVALID=%b required 1", BVALID);
    end
    resp = BRESP;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    #1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (ARREADY !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
    end
    @(negedge ACLK);
    ARVALID = 1'b0;
    n = 0;
    while (RVALID !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    if (RVALID !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL r_timeout: RVALID=%b required 1", RVALID);
    end
    d = RDATA;
    resp = RRESP;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    n_cmp++; if (AWREADY !== 1'b0) begin n_err++; $display("FAIL rst_awready: got %b want 0", AWREADY); end
    n_cmp++; if (WREADY  !== 1'b0) begin n_err++; $display("FAIL rst_wready: got %b want 0", WREADY); end
    n_cmp++; if (BVALID  !== 1'b0) begin n_err++; $display("FAIL rst_bvalid: got %b want 0", BVALID); end
    n_cmp++; if (BRESP   !== 2'b00) begin n_err++; $display("FAIL rst_bresp: got %b want 00", BRESP); end
    n_cmp++; if (ARREADY !== 1'b0) begin n_err++; $display("FAIL rst_arready: got %b want 0", ARREADY); end
    n_cmp++; if (RVALID  !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", RVALID); end
    n_cmp++; if (RRESP   !== 2'b00) begin n_err++; $display("FAIL rst_rresp: got %b want 00", RRESP); end
    n_cmp++; if (RDATA   !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", RDATA); end
    n_cmp++; if (IRQ     !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", IRQ); end
    ARESET = 1'b0;
    model_q.delete();
    model_thresh = DEPTH / 2;
    n_cmp++; if (ARREADY !== 1'b0) begin n_err++; $display("FAIL rst_release_arready: got %b want 0", ARREADY); end
    axi_read(4'h4, d, r);
    n_cmp++; if (d !== 32'h4000_0000 || r !== 2'b00) begin n_err++; $display("FAIL rst_status: got %h/%b want 40000000/00", d, r); end
    axi_read(4'hC, d, r);
    n_cmp++; if (d !== 32'd8 || r !== 2'b00) begin n_err++; $display("FAIL rst_thresh: got %h/%b want 8/00", d, r); end
  endtask

  task automatic test_push_pop();
    logic [31:0] d;
    logic [1:0]  r, er;
    exp_write(4'h0, 32'hA5A5_0001, 4'hF, er);
    axi_write(4'h0, 32'hA5A5_0001, 4'hF, r);
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL pp_wr1_resp: got %b want 00", r); end
    exp_write(4'h1 & 4'h3, 32'hA5A5_0002, 4'hF, er);
    axi_write(4'h3, 32'hA5A5_0002, 4'hF, r);
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL pp_wr2_resp: got %b want 00", r); end
    axi_read(4'h0, d, r);
    void'(model_q.pop_front());
    n_cmp++; if (d !== 32'hA5A5_0001 || r !== 2'b00) begin n_err++; $display("FAIL pp_rd1: got %h/%b want a5a50001/00", d, r); end
    axi_read(4'h2, d, r);
    void'(model_q.pop_front());
    n_cmp++; if (d !== 32'hA5A5_0002 || r !== 2'b00) begin n_err++; $display("FAIL pp_rd2: got %h/%b want a5a50002/00", d, r); end
    axi_read(4'h4, d, r);
    n_cmp++; if (d !== 32'h4000_0000 || r !== 2'b00) begin n_err++; $display("FAIL pp_status: got %h/%b want 40000000/00", d, r); end
  endtask

  task automatic test_empty();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(4'h0, d, r);
    n_cmp++; if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL empty_pop: got %h/%b want 0/10", d, r); end
    axi_read(4'h4, d, r);
    n_cmp++; if (d !== 32'h4000_0000) begin n_err++; $display("FAIL empty_status: got %h want 40000000", d); end
    axi_read(4'h8, d, r);
    n_cmp++; if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL ctrl_read: got %h/%b want 0/10", d, r); end
  endtask

  task automatic test_full();
    logic [31:0] words[17];
    logic [31:0] d;
    logic [1:0]  r, er;
    for (int i = 0; i < 17; i++) begin
      words[i] = $urandom;
      exp_write(4'h0, words[i], 4'hF, er);
      axi_write(4'h0, words[i], 4'hF, r);
      n_cmp++;
      if (r !== ((i < 16) ? 2'b00 : 2'b10)) begin
        n_err++; $display("FAIL full_push%0d: got %b want %b", i + 1, r, (i < 16) ? 2'b00 : 2'b10);
      end
    end
    axi_read(4'h4, d, r);
    n_cmp++; if (d !== 32'h8000_0010) begin n_err++; $display("FAIL full_status: got %h want 80000010", d); end
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL full_irq: got %b want 1", IRQ); end
    axi_read(4'h0, d, r);
    void'(model_q.pop_front());
    n_cmp++; if (d !== words[0] || r !== 2'b00) begin n_err++; $display("FAIL full_pop: got %h/%b want %h/00", d, r, words[0]); end
    exp_write(4'h8, 32'h1, 4'hF, er);
    axi_write(4'h8, 32'h1, 4'hF, r);
    axi_read(4'h4, d, r);
    n_cmp++; if (d !== 32'h4000_0000) begin n_err++; $display("FAIL full_flush_status: got %h want 40000000", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [1:0]  r, er;
    exp_write(4'hC, 32'h3, 4'hF, er);
    axi_write(4'hC, 32'h3, 4'hF, r);
    for (int i = 0; i < 3; i++) begin
      exp_write(4'h0, 32'h100 + i, 4'hF, er);
      axi_write(4'h0, 32'h100 + i, 4'hF, r);
      n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_push%0d_now: got %b want 0", i + 1, IRQ); end
      @(negedge ACLK);
      n_cmp++;
      if (IRQ !== ((i == 2) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL irq_push%0d_late: got %b want %b", i + 1, IRQ, (i == 2));
      end
    end
    axi_read(4'h0, d, r);
    void'(model_q.pop_front());
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL irq_pop_now: got %b want 1", IRQ); end
    @(negedge ACLK);
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_pop_late: got %b want 0", IRQ); end
    exp_write(4'h8, 32'h1, 4'h1, er);
    axi_write(4'h8, 32'h1, 4'h1, r);
    exp_write(4'hC, 32'h0, 4'hF, er);
    axi_write(4'hC, 32'h0, 4'hF, r);
    @(negedge ACLK);
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL irq_thresh0: got %b want 1", IRQ); end
    exp_write(4'hC, 32'hFFFF_FF08, 4'h1, er);
    axi_write(4'hC, 32'hFFFF_FF08, 4'h1, r);
    axi_read(4'hC, d, r);
    n_cmp++; if (d !== 32'h8 || r !== 2'b00) begin n_err++; $display("FAIL irq_thresh_lane: got %h/%b want 8/00", d, r); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] d, d2;
    logic [1:0]  r, er;
    int n;
    @(negedge ACLK);
    AWADDR = 4'h0; WDATA = 32'h1111_2222; WSTRB = 4'h3; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    #1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    n_cmp++; if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin n_err++; $display("FAIL stall_accept: got AWREADY=%b WREADY=%b want 1/1", AWREADY, WREADY); end
    @(negedge ACLK);
    d2 = $urandom;
    WDATA = d2; WSTRB = 4'hF;
    #1;
    n_cmp++; if (BVALID !== 1'b1 || BRESP !== 2'b10) begin n_err++; $display("FAIL stall_b_latency: got %b/%b want 1/10", BVALID, BRESP); end
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      n_cmp++;
      if (BVALID !== 1'b1 || BRESP !== 2'b10 || AWREADY !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: got BVALID=%b BRESP=%b AWREADY=%b want 1/10/0", i, BVALID, BRESP, AWREADY);
      end
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    n_cmp++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL stall_release: AWREADY=%b want 1", AWREADY); end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    exp_write(4'h0, d2, 4'hF, er);
    n_cmp++; if (BVALID !== 1'b1 || BRESP !== er) begin n_err++; $display("FAIL stall_second_resp: got %b/%b want 1/%b", BVALID, BRESP, er); end
    exp_write(4'h8, 32'h1, 4'hF, er);
    axi_write(4'h8, 32'h1, 4'hF, r);
    n_cmp++; if (r !== 2'b00) begin n_err++; $display("FAIL flush_resp: got %b want 00", r); end
    axi_read(4'h4, d, r);
    n_cmp++; if (d !== 32'h4000_0000) begin n_err++; $display("FAIL flush_status: got %h want 40000000", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, w1, w2;
    logic [1:0]  r, er;
    int n;
    w1 = $urandom; w2 = $urandom;
    exp_write(4'h0, w1, 4'hF, er); axi_write(4'h0, w1, 4'hF, r);
    exp_write(4'h0, w2, 4'hF, er); axi_write(4'h0, w2, 4'hF, r);
    @(negedge ACLK);
    ARADDR = 4'h0; ARVALID = 1'b1; RREADY = 1'b0;
    #1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    ARVALID = 1'b0;
    n_cmp++; if (RVALID !== 1'b1 || RDATA !== w1) begin n_err++; $display("FAIL midrst_rvalid: got %b/%h want 1/%h", RVALID, RDATA, w1); end
    ARESET = 1'b1;
    @(negedge ACLK);
    n_cmp++; if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin n_err++; $display("FAIL midrst_abandon: got RVALID=%b ARREADY=%b want 0/0", RVALID, ARREADY); end
    ARESET = 1'b0;
    RREADY = 1'b1;
    model_q.delete();
    model_thresh = DEPTH / 2;
    @(negedge ACLK);
    n_cmp++; if (RVALID !== 1'b0 || BVALID !== 1'b0) begin n_err++; $display("FAIL midrst_pending: got RVALID=%b BVALID=%b want 0/0", RVALID, BVALID); end
    axi_read(4'h4, d, r);
    n_cmp++; if (d !== 32'h4000_0000) begin n_err++; $display("FAIL midrst_status: got %h want 40000000", d); end
  endtask

  task automatic test_random();
    logic [3:0]  a, s;
    logic [31:0] d, ed, rd;
    logic [1:0]  r, er;
    int op;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 99);
      d  = $urandom;
      s  = 4'hF;
      if (op < 45) begin
        a = {2'd0, 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 14));
        exp_write(a, d, s, er);
        axi_write(a, d, s, r);
        n_cmp++; if (r !== er) begin n_err++; $display("FAIL rand_push[%0d]: got %b want %b", i, r, er); end
      end else if (op < 85) begin
        a = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        if (a[3:2] == 2'd2 && $urandom_range(0, 3) != 0) a[3:2] = 2'd0;
        exp_read(a, ed, er);
        axi_read(a, rd, r);
        n_cmp++; if (rd !== ed || r !== er) begin n_err++; $display("FAIL rand_read[%0d] addr=%h: got %h/%b want %h/%b", i, a, rd, r, ed, er); end
      end else if (op < 93) begin
        a = {2'd3, 2'($urandom_range(0, 3))};
        d[7:0] = 8'($urandom_range(0, 16));
        s = 4'($urandom_range(0, 15));
        exp_write(a, d, s, er);
        axi_write(a, d, s, r);
        n_cmp++; if (r !== er) begin n_err++; $display("FAIL rand_thresh_wr[%0d]: got %b want %b", i, r, er); end
      end else begin
        a = {2'd2, 2'($urandom_range(0, 3))};
        d[0] = ($urandom_range(0, 2) == 0);
        s = 4'($urandom_range(0, 15));
        exp_write(a, d, s, er);
        axi_write(a, d, s, r);
        n_cmp++; if (r !== er) begin n_err++; $display("FAIL rand_ctrl_wr[%0d]: got %b want %b", i, r, er); end
      end
      @(negedge ACLK);
      n_cmp++; if (IRQ !== exp_irq()) begin n_err++; $display("FAIL rand_irq[%0d]: got %b want %b", i, IRQ, exp_irq()); end
    end
    axi_read(4'h4, rd, r);
    n_cmp++; if (rd !== exp_status()) begin n_err++; $display("FAIL rand_final_status: got %h want %h", rd, exp_status()); end
  endtask

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; AWPROT = 3'b000; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; ARPROT = 3'b000; RREADY = 1'b0;
    test_reset();
    test_push_pop();
    test_empty();
    test_full();
    test_irq();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
